// File: rtl/coolgirl_detect_pkg.sv
// Shared types for famiclone detection and the cartridge top-level tri-state logic.
// CIRAM mode encoding is consumed directly by the ppu_not_a13 / ppu_ciram_ce drivers.
package coolgirl_detect_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    DRIVE  = 2'd1,
    HIZ    = 2'd2
  } ciram_mode_t;

  // Bits needed to hold values 0..v inclusive.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v == 0) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/famiclone_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the probe read and mismatch tallies.
module sat_counter #(
  parameter int unsigned W     = 2,
  parameter int unsigned LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/famiclone_detect.sv
// Power-on ground phase plus PPU read probe deciding whether the console ignores CIRAM /CE.
// Define COOLGIRL_MISMATCH_VOTE_EN to require MISMATCH_THRESH mismatches instead of one.
module famiclone_detect
  import coolgirl_detect_pkg::*;
#(
  parameter int unsigned INIT_CYCLES     = 15,
  parameter int unsigned PROBE_READS     = 3,
  parameter int unsigned MISMATCH_THRESH = 2
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_rd_evt,
  input  logic       ppu_a13,
  input  logic       ppu_not_a13,
  input  logic       redetect,
  output logic       ground_en,
  output logic       init_done,
  output logic       detect_done,
  output logic       new_dendy,
  output logic [1:0] ciram_mode
);

  if (INIT_CYCLES == 0 || PROBE_READS == 0 || MISMATCH_THRESH == 0) begin : g_bad_param
    $error("famiclone_detect: INIT_CYCLES, PROBE_READS and MISMATCH_THRESH must all be >= 1");
  end

`ifdef COOLGIRL_MISMATCH_VOTE_EN
  localparam int unsigned THRESH = MISMATCH_THRESH;
`else
  localparam int unsigned THRESH = 1;
`endif
  localparam int unsigned IW = cnt_width(INIT_CYCLES);
  localparam int unsigned PW = cnt_width(PROBE_READS);

  state_t      state_q, state_n;
  ciram_mode_t mode_q, mode_n;
  logic [IW-1:0] init_q, init_n;
  logic ground_n, init_done_n, detect_n, dendy_n;

  logic [PW-1:0] lo_cnt, hi_cnt;
  logic lo_full, hi_full, lo_inc, hi_inc, cnt_clr;
  logic lo_step, hi_step, mis_step, mis_hit, lo_post, hi_post;

  // Mismatches only count while both polarity windows are still open.
  assign mis_step = ppu_rd_evt && (ppu_a13 == ppu_not_a13) && !lo_full && !hi_full;
  assign lo_step  = ppu_rd_evt && !ppu_a13 && !lo_full;
  assign hi_step  = ppu_rd_evt &&  ppu_a13 && !hi_full;
  assign lo_post  = lo_full || (lo_step && lo_cnt == PW'(PROBE_READS - 1));
  assign hi_post  = hi_full || (hi_step && hi_cnt == PW'(PROBE_READS - 1));

  sat_counter #(.W(PW), .LIMIT(PROBE_READS)) u_lo_cnt (
    .clk(m2), .rst(reset), .inc(lo_inc), .clr(cnt_clr), .count(lo_cnt), .at_limit(lo_full)
  );

  sat_counter #(.W(PW), .LIMIT(PROBE_READS)) u_hi_cnt (
    .clk(m2), .rst(reset), .inc(hi_inc), .clr(cnt_clr), .count(hi_cnt), .at_limit(hi_full)
  );

`ifdef COOLGIRL_MISMATCH_VOTE_EN
  localparam int unsigned MW = cnt_width(THRESH);
  logic [MW-1:0] mis_cnt;
  logic          mis_full, mis_inc;

  sat_counter #(.W(MW), .LIMIT(THRESH)) u_mis_cnt (
    .clk(m2), .rst(reset), .inc(mis_inc), .clr(cnt_clr), .count(mis_cnt), .at_limit(mis_full)
  );

  assign mis_hit = mis_full || (mis_step && mis_cnt == MW'(THRESH - 1));
`else
  assign mis_hit = mis_step;
`endif

  always_comb begin
    state_n     = state_q;
    mode_n      = mode_q;
    init_n      = init_q;
    ground_n    = ground_en;
    init_done_n = init_done;
    detect_n    = detect_done;
    dendy_n     = new_dendy;
    lo_inc      = 1'b0;
    hi_inc      = 1'b0;
    cnt_clr     = 1'b0;
`ifdef COOLGIRL_MISMATCH_VOTE_EN
    mis_inc     = 1'b0;
`endif
    unique case (state_q)
      INIT: begin
        if (init_q == '0) begin
          state_n     = PROBE;
          ground_n    = 1'b0;
          init_done_n = 1'b1;
          mode_n      = DRIVE;
        end else begin
          init_n = init_q - 1'b1;
        end
      end
      PROBE, DONE: begin
        if (redetect) begin
          state_n  = PROBE;
          cnt_clr  = 1'b1;
          dendy_n  = 1'b0;
          detect_n = 1'b0;
          mode_n   = DRIVE;
        end else if (state_q == PROBE && ppu_rd_evt) begin
          lo_inc = lo_step;
          hi_inc = hi_step;
`ifdef COOLGIRL_MISMATCH_VOTE_EN
          mis_inc = mis_step;
`endif
          if (mis_hit) begin
            state_n  = DONE;
            dendy_n  = 1'b1;
            detect_n = 1'b1;
            mode_n   = HIZ;
          end else if (lo_post && hi_post) begin
            state_n  = DONE;
            dendy_n  = 1'b0;
            detect_n = 1'b1;
            mode_n   = DRIVE;
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      mode_q      <= GROUND;
      init_q      <= IW'(INIT_CYCLES - 1);
      ground_en   <= 1'b1;
      init_done   <= 1'b0;
      detect_done <= 1'b0;
      new_dendy   <= 1'b0;
    end else begin
      state_q     <= state_n;
      mode_q      <= mode_n;
      init_q      <= init_n;
      ground_en   <= ground_n;
      init_done   <= init_done_n;
      detect_done <= detect_n;
      new_dendy   <= dendy_n;
    end
  end

  assign ciram_mode = mode_q;

endmodule

// File: tb/tb_famiclone_detect.sv
// Directed bench for famiclone_detect; expectations follow COOLGIRL_MISMATCH_VOTE_EN when defined.
module tb_famiclone_detect;

  logic       m2 = 1'b0;
  logic       reset, ppu_rd_evt, ppu_a13, ppu_not_a13, redetect;
  logic       ground_en, init_done, detect_done, new_dendy;
  logic [1:0] ciram_mode;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  // {ground_en, init_done, detect_done, new_dendy, ciram_mode}
  localparam logic [5:0] E_INIT  = 6'b1000_00;
  localparam logic [5:0] E_PROBE = 6'b0100_01;
  localparam logic [5:0] E_OK    = 6'b0110_01;
  localparam logic [5:0] E_DENDY = 6'b0111_10;

  famiclone_detect #(.INIT_CYCLES(15), .PROBE_READS(3), .MISMATCH_THRESH(2)) dut (
    .m2(m2), .reset(reset), .ppu_rd_evt(ppu_rd_evt), .ppu_a13(ppu_a13),
    .ppu_not_a13(ppu_not_a13), .redetect(redetect), .ground_en(ground_en),
    .init_done(init_done), .detect_done(detect_done), .new_dendy(new_dendy),
    .ciram_mode(ciram_mode)
  );

  always #5 m2 = ~m2;

  task automatic expect_out(input logic [5:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [5:0] e, obs;
    string tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {ground_en, init_done, detect_done, new_dendy, ciram_mode};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic evt, input logic a13, input logic na13, input logic redet,
                      input logic [5:0] e, input string tag);
    ppu_rd_evt  = evt;
    ppu_a13     = a13;
    ppu_not_a13 = na13;
    redetect    = redet;
    expect_out(e, tag);
    @(posedge m2);
    #1;
    check_out();
  endtask

  task automatic ground_phase(input string tag);
    for (int unsigned i = 1; i < 15; i++)
      step(i[0], 1'b0, 1'b0, (i == 7), E_INIT, tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, E_PROBE, {tag, "_edge15"});
  endtask

  initial begin
    reset = 1'b1; ppu_rd_evt = 1'b0; ppu_a13 = 1'b0; ppu_not_a13 = 1'b0; redetect = 1'b0;
    #12;
    expect_out(E_INIT, "reset_vals");
    check_out();
    reset = 1'b0;

    // Ground phase with mismatching events and a redetect pulse that must be ignored.
    ground_phase("init");

    // Normal console; lo saturates, mismatches after lo is full are not counted.
    step(1, 0, 1, 0, E_PROBE, "nes_lo1");
    step(1, 0, 1, 0, E_PROBE, "nes_lo2");
    step(0, 0, 0, 0, E_PROBE, "nes_idle");
    step(1, 0, 1, 0, E_PROBE, "nes_lo3");
    step(1, 0, 1, 0, E_PROBE, "nes_lo_sat");
    step(1, 0, 0, 0, E_PROBE, "nes_late_mis_lo");
    step(1, 1, 1, 0, E_PROBE, "nes_late_mis_hi");
    step(1, 1, 0, 0, E_PROBE, "nes_hi2");
    step(1, 1, 0, 0, E_OK,    "nes_verdict");
    step(1, 0, 0, 0, E_OK,    "done_hold");

    // Famiclone probe.
    step(0, 0, 0, 1, E_PROBE, "redet_from_ok");
`ifdef COOLGIRL_MISMATCH_VOTE_EN
    step(1, 0, 0, 0, E_PROBE, "dendy_mis1");
`else
    step(1, 0, 0, 0, E_DENDY, "dendy_mis1");
`endif
    step(1, 1, 1, 0, E_DENDY, "dendy_mis2");

    // Redetect with a same-cycle mismatch: event dropped, counters cleared.
    step(1, 0, 0, 1, E_PROBE, "redet_evt_drop");
    step(1, 0, 1, 0, E_PROBE, "clr_lo1");
    step(1, 0, 1, 0, E_PROBE, "clr_lo2");
    step(1, 1, 0, 0, E_PROBE, "clr_hi1");
    step(1, 1, 0, 0, E_PROBE, "clr_hi2");
    step(1, 0, 1, 0, E_PROBE, "clr_lo3");
    step(1, 1, 0, 0, E_OK,    "clr_verdict");

    // One mismatch then five clean reads.
    step(0, 0, 0, 1, E_PROBE, "vote_redet");
`ifdef COOLGIRL_MISMATCH_VOTE_EN
    step(1, 0, 0, 0, E_PROBE, "vote_mis1");
    step(1, 0, 1, 0, E_PROBE, "vote_c1");
    step(1, 0, 1, 0, E_PROBE, "vote_c2");
    step(1, 1, 0, 0, E_PROBE, "vote_c3");
    step(1, 1, 0, 0, E_PROBE, "vote_c4");
    step(1, 1, 0, 0, E_OK,    "vote_c5");
`else
    step(1, 0, 0, 0, E_DENDY, "vote_mis1");
    step(1, 0, 1, 0, E_DENDY, "vote_c1");
    step(1, 0, 1, 0, E_DENDY, "vote_c2");
    step(1, 1, 0, 0, E_DENDY, "vote_c3");
    step(1, 1, 0, 0, E_DENDY, "vote_c4");
    step(1, 1, 0, 0, E_DENDY, "vote_c5");
`endif

    // Mismatches after hi has saturated are not counted.
    step(0, 0, 0, 1, E_PROBE, "late_redet");
    step(1, 1, 0, 0, E_PROBE, "late_hi1");
    step(1, 1, 0, 0, E_PROBE, "late_hi2");
    step(1, 1, 0, 0, E_PROBE, "late_hi3");
    step(1, 0, 0, 0, E_PROBE, "late_mis_a");
    step(1, 1, 1, 0, E_PROBE, "late_mis_b");
    step(1, 0, 0, 0, E_PROBE, "late_mis_c");
    step(1, 0, 1, 0, E_OK,    "late_verdict");

    // Reset mid-probe returns to reset values immediately and repeats the ground phase.
    step(0, 0, 0, 1, E_PROBE, "mid_redet");
    step(1, 0, 1, 0, E_PROBE, "mid_rd1");
    step(1, 1, 0, 0, E_PROBE, "mid_rd2");
    #2;
    reset = 1'b1;
    #1;
    expect_out(E_INIT, "mid_reset_async");
    check_out();
    step(1, 0, 0, 0, E_INIT, "reset_held");
    reset = 1'b0;
    ground_phase("reinit");
`ifdef COOLGIRL_MISMATCH_VOTE_EN
    step(1, 0, 0, 0, E_PROBE, "post_reinit_mis");
`else
    step(1, 0, 0, 0, E_DENDY, "post_reinit_mis");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/famiclone_detect.md
Name: famiclone_detect

Overview:
- Parametrised successor to the cartridge's power-on famiclone handling.
- Holds PPU /A13 and CIRAM /CE grounded for a configurable number of M2 cycles after reset.
- Then probes PPU reads to decide whether the console is a "new Dendy" famiclone that ignores CIRAM /CE, using configurable read counts and a mismatch threshold.
- Adds software re-detection and a debounced verdict. Sits beside the mapper core; its outputs drive the ppu_not_a13 and ppu_ciram_ce tri-state logic in the cartridge top level.

Parameters:
- INIT_CYCLES, 15: number of M2 cycles the ground phase lasts after reset release (must be ≥1).
- PROBE_READS, 3: PPU reads required per A13 polarity before the probe window closes (must be ≥1).
- MISMATCH_THRESH, 2: mismatches needed to declare new Dendy; used only when MISMATCH_VOTE_EN is defined (must be ≥1).

Ports:
- m2  in  1  CPU M2 clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ppu_rd_evt  in  1  one-m2-cycle pulse per captured PPU read (capture logic upstream).
- ppu_a13  in  1  PPU A13 captured with the event.
- ppu_not_a13  in  1  /A13 line level captured with the event.
- redetect  in  1  one-cycle pulse from mapper register write; restarts the probe.
- ground_en  out  1  1 = drive /A13 and CIRAM /CE to 0.
- init_done  out  1  ground phase finished.
- detect_done  out  1  verdict valid.
- new_dendy  out  1  verdict: famiclone detected.
- ciram_mode  out  2  0 = GROUND, 1 = DRIVE (~A13), 2 = HIZ; 3 is never produced.

Behaviour:
- Reset values (asynchronous): state INIT, init counter = INIT_CYCLES-1, lo_cnt = hi_cnt = mis_cnt = 0, ground_en = 1, init_done = 0, detect_done = 0, new_dendy = 0, ciram_mode = GROUND.
- All outputs are registered.

State INIT:
- Init counter decrements each rising edge.
- On the edge where the counter equals 0: next state PROBE, ground_en 0, init_done 1, ciram_mode DRIVE.
- Ground is therefore held for exactly INIT_CYCLES rising edges after reset deasserts.
- ppu_rd_evt and redetect are ignored in INIT.

State PROBE:
- On ppu_rd_evt, evaluate using pre-update counter values.
- Mismatch is counted only when ppu_a13 == ppu_not_a13 (they are expected to be complementary) AND lo_cnt < PROBE_READS AND hi_cnt < PROBE_READS. A mismatch increments mis_cnt, saturating at the threshold.
- If ppu_a13 = 0 and lo_cnt < PROBE_READS: lo_cnt++. If ppu_a13 = 1 and hi_cnt < PROBE_READS: hi_cnt++. Both counters saturate.
- Verdict new_dendy is reached when mis_cnt post-update reaches the threshold. Then: new_dendy 1, detect_done 1, ciram_mode HIZ, next state DONE, all on the same edge.
- Otherwise, when lo_cnt and hi_cnt both reach PROBE_READS (post-update): detect_done 1, new_dendy 0, ciram_mode DRIVE, next DONE.
- A single event can both complete the count and exceed the threshold; the new_dendy verdict takes priority.

State DONE:
- Outputs hold; ppu_rd_evt is ignored.

redetect (PROBE or DONE):
- Next state PROBE; lo_cnt, hi_cnt, mis_cnt, new_dendy and detect_done cleared; ciram_mode DRIVE.
- Ground phase is not re-entered.
- redetect takes priority over a same-cycle ppu_rd_evt; that event is dropped.

Widths:
- Counters are $clog2(PARAM+1) bits.
- Elaboration fails if any parameter is 0.

Reset mid-operation: returns to INIT and the full ground phase repeats.

Optional Feature:
- COOLGIRL_MISMATCH_VOTE_EN defined: threshold = MISMATCH_THRESH, and mis_cnt is implemented.
- Undefined: threshold fixed at 1. mis_cnt is omitted, and the first qualifying mismatch sets new_dendy (legacy behaviour).

Decomposition:
- Package coolgirl_detect_pkg holds the following, shared with the top level's tri-state logic:
  - state enum: INIT, PROBE, DONE.
  - ciram_mode enum: GROUND = 0, DRIVE = 1, HIZ = 2.
  - width helper function.
- One sub-module, sat_counter (parametrised width/limit, inc, clr, at_limit), instantiated for lo_cnt, hi_cnt and mis_cnt.
- The init down-counter stays inline.

Test Plan:
1. Reset, INIT_CYCLES=15: ground_en=1 and ciram_mode=0 for exactly 15 rising edges; init_done=1 on the 15th edge. Events during INIT leave lo_cnt/hi_cnt at 0.
2. Normal NES, PROBE_READS=3, vote undefined: 3 reads with a13=0,n=1 and 3 with a13=1,n=0 → detect_done=1, new_dendy=0, ciram_mode=1 on the 6th event edge.
3. Famiclone, vote undefined: first read with a13=0,n=0 → new_dendy=1, detect_done=1, ciram_mode=2 on the same edge.
4. Vote defined, THRESH=2: one mismatch then 5 clean reads → new_dendy=0. Rerun with 2 mismatches before the window closes → new_dendy=1. A mismatch arriving after hi_cnt=3 is not counted.
5. From DONE with new_dendy=1, pulse redetect together with ppu_rd_evt (mismatch) → next cycle PROBE, new_dendy=0, detect_done=0, counters 0, ground_en stays 0.
6. Assert reset during PROBE after 2 reads → all outputs return to reset values immediately; ground phase runs a full 15 cycles again.
